y86_imem_loader: RTL and testbench

- Writer side of the Y86-64 instruction memory.
- Accepts a length-prefixed byte stream over a valid/ready handshake and writes the payload into instruction memory starting at byte address 0.
- Holds the SEQ processor off (`cpu_run` low) until the image is completely written, then releases it.
- Sits between the host/test byte source and the instruction-memory write port; the processor's fetch stage is the reader of what this block writes.

---
 rtl/y86_imem_loader.sv | 189 ++++++++++++++++++
 tb/tb_y86_imem_loader.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_imem_loader.sv
// Y86-64 instruction-memory loader: length-prefixed byte stream in, byte writes out.
// Holds cpu_run low until the image is fully committed. Optional macro: LOADER_CHECKSUM_EN.
module y86_imem_loader #(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W:0]   byte_count,
  output logic              cpu_run,
  output logic              load_err
);

  typedef enum logic [2:0] {
    StLen0,
    StLen1,
    StData,
`ifdef LOADER_CHECKSUM_EN
    StChk,
`endif
    StDrain,
    StDone,
    StErr
  } state_e;

  // State entered once the payload (possibly empty) has been consumed.
`ifdef LOADER_CHECKSUM_EN
  localparam state_e StPayloadEnd = StChk;
`else
  localparam state_e StPayloadEnd = StDrain;
`endif

  localparam logic [15:0] LenMax = 16'(IMEM_DEPTH);

  state_e            r_state;
  state_e            w_state_d;
  logic [7:0]        r_len_lo;
  logic [7:0]        w_len_lo_d;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   w_len_d;
  logic [ADDR_W:0]   r_byte_count;
  logic [ADDR_W:0]   w_byte_count_d;
  logic [ADDR_W:0]   w_count_inc;
  logic [15:0]       w_len_full;
  logic              w_xfer;
  logic              w_wr;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_cpu_run;
  logic              r_load_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
  logic [7:0]        w_csum_d;
`endif

  assign w_xfer      = in_valid & in_ready;
  assign w_len_full  = {in_data, r_len_lo};
  assign w_count_inc = r_byte_count + (ADDR_W + 1)'(1);

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      StLen0, StLen1, StData: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      StChk:                  in_ready = 1'b1;
`endif
      default:                in_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_state_d      = r_state;
    w_len_lo_d     = r_len_lo;
    w_len_d        = r_len;
    w_byte_count_d = r_byte_count;
    w_wr           = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    w_csum_d       = r_csum;
`endif
    case (r_state)
      StLen0: begin
        if (w_xfer) begin
          w_len_lo_d = in_data;
          w_state_d  = StLen1;
        end
      end
      StLen1: begin
        if (w_xfer) begin
          // Truncation is harmless: an oversize length never leaves StErr via StData.
          w_len_d = w_len_full[ADDR_W:0];
          if (w_len_full > LenMax) begin
            w_state_d = StErr;
          end else if (w_len_full == 16'd0) begin
            w_state_d = StPayloadEnd;
          end else begin
            w_state_d = StData;
          end
        end
      end
      StData: begin
        if (w_xfer) begin
          w_wr           = 1'b1;
          w_byte_count_d = w_count_inc;
`ifdef LOADER_CHECKSUM_EN
          w_csum_d       = r_csum ^ in_data;
`endif
          if (w_count_inc == r_len) begin
            w_state_d = StPayloadEnd;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (w_xfer) begin
          w_state_d = (in_data == r_csum) ? StDrain : StErr;
        end
      end
`endif
      StDrain: begin
        w_state_d = StDone;
      end
      StDone, StErr: begin
        if (reload) begin
          w_state_d      = StLen0;
          w_byte_count_d = '0;
`ifdef LOADER_CHECKSUM_EN
          w_csum_d       = '0;
`endif
        end
      end
      default: begin
        w_state_d = StLen0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StLen0;
      r_len_lo     <= '0;
      r_len        <= '0;
      r_byte_count <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_run    <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_len_lo     <= w_len_lo_d;
      r_len        <= w_len_d;
      r_byte_count <= w_byte_count_d;
      r_mem_we     <= w_wr;
      if (w_wr) begin
        r_mem_addr  <= r_byte_count[ADDR_W-1:0];
        r_mem_wdata <= in_data;
      end
      // Lags StDone by one edge so the last write has long committed before release.
      r_cpu_run    <= (r_state == StDone) && !reload;
      r_load_err   <= (w_state_d == StErr);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum <= '0;
    end else begin
      r_csum <= w_csum_d;
    end
  end
`endif

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign byte_count = r_byte_count;
  assign cpu_run    = r_cpu_run;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_y86_imem_loader.sv
// Self-checking bench for y86_imem_loader; builds with or without LOADER_CHECKSUM_EN.
module tb_y86_imem_loader;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          reload;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [AW:0]   byte_count;
  logic          cpu_run;
  logic          load_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]    mem     [DEPTH];
  logic [7:0]    exp_mem [DEPTH];
  int unsigned   we_count = 0;
  logic [AW+7:0] wlog[$];

  y86_imem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .byte_count (byte_count),
    .cpu_run    (cpu_run),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // Instruction memory itself: mem_we is high for a whole cycle, so each negedge sees it once.
  always @(negedge clk) begin
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      we_count      = we_count + 1;
      wlog.push_back({mem_addr, mem_wdata});
    end
  end

  // Reference stream: LEN lo, LEN hi, payload, then XOR checksum when enabled.
  function automatic bq_t make_stream(bq_t payload);
    bq_t         s;
    logic [15:0] len;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  x = 8'h00;
`endif
    len = 16'(payload.size());
    s.push_back(len[7:0]);
    s.push_back(len[15:8]);
    foreach (payload[i]) begin
      s.push_back(payload[i]);
`ifdef LOADER_CHECKSUM_EN
      x = x ^ payload[i];
`endif
    end
`ifdef LOADER_CHECKSUM_EN
    s.push_back(x);
`endif
    return s;
  endfunction

  function automatic bq_t rand_payload(int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic void commit_model(bq_t p);
    foreach (p[i]) exp_mem[i] = p[i];
  endfunction

  // All drivers start and end just after a negedge.
  task automatic send_byte(input logic [7:0] b);
    int unsigned waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_byte_timeout: in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_stream(input bq_t s, input bit gaps);
    foreach (s[i]) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      send_byte(s[i]);
    end
  endtask

  task automatic wait_run(output int unsigned n);
    n = 0;
    while (!cpu_run && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %0h want 0", mem_wdata); end
    checks++; if (byte_count !== '0) begin errors++; $display("FAIL reset_byte_count: got %0d want 0", byte_count); end
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL reset_cpu_run: got %0b want 0", cpu_run); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %0b want 0", load_err); end
  endtask

  task automatic test_basic();
    bq_t         p = '{8'h30, 8'hF0, 8'h0A};
    int unsigned n;
    send_stream(make_stream(p), 1'b0);
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL basic_early_run: got %0b want 0", cpu_run); end
    wait_run(n);
    checks++; if (n != 2) begin errors++; $display("FAIL basic_run_latency: got %0d edges want 2", n); end
    checks++; if (byte_count !== 11'd3) begin errors++; $display("FAIL basic_byte_count: got %0d want 3", byte_count); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL basic_load_err: got %0b want 0", load_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready: got %0b want 0", in_ready); end
    commit_model(p);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin
        errors++; $display("FAIL basic_mem[%0d]: got %0h want %0h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_max_len();
    bq_t         p;
    int unsigned n;
    int          bad = 0;
    do_reload();
    p = rand_payload(DEPTH);
    send_stream(make_stream(p), 1'b0);
    wait_run(n);
    checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL maxlen_cpu_run: got %0b want 1", cpu_run); end
    checks++; if (byte_count !== 11'd1024) begin errors++; $display("FAIL maxlen_byte_count: got %0d want 1024", byte_count); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL maxlen_load_err: got %0b want 0", load_err); end
    commit_model(p);
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL maxlen_mem: got %0d wrong bytes want 0", bad); end
  endtask

  task automatic test_random_gaps();
    bq_t         p;
    int unsigned n;
    do_reload();
    wlog.delete();
    p = rand_payload(16);
    send_stream(make_stream(p), 1'b1);
    wait_run(n);
    checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL gaps_cpu_run: got %0b want 1", cpu_run); end
    checks++; if (wlog.size() != 16) begin errors++; $display("FAIL gaps_write_count: got %0d want 16", wlog.size()); end
    for (int i = 0; i < 16 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i] !== {AW'(i), p[i]}) begin
        errors++; $display("FAIL gaps_write[%0d]: got %0h want %0h", i, wlog[i], {AW'(i), p[i]});
      end
    end
    commit_model(p);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin
        errors++; $display("FAIL gaps_mem[%0d]: got %0h want %0h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_oversize();
    int unsigned we0;
    int unsigned n;
    bq_t         empty;
    do_reload();
    we0 = we_count;
    send_byte(8'h01);
    send_byte(8'h04);
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL over_load_err: got %0b want 1", load_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL over_in_ready: got %0b want 0", in_ready); end
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL over_cpu_run: got %0b want 0", cpu_run); end
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL over_sticky: got %0b want 1", load_err); end
    checks++; if (we_count != we0) begin errors++; $display("FAIL over_no_write: got %0d writes want 0", we_count - we0); end
    do_reload();
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL over_reload_err: got %0b want 0", load_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL over_reload_ready: got %0b want 1", in_ready); end
    send_stream(make_stream(empty), 1'b0);
    wait_run(n);
    checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL zero_cpu_run: got %0b want 1", cpu_run); end
    checks++; if (byte_count !== '0) begin errors++; $display("FAIL zero_byte_count: got %0d want 0", byte_count); end
    checks++; if (we_count != we0) begin errors++; $display("FAIL zero_no_write: got %0d writes want 0", we_count - we0); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bq_t         p = '{8'h10, 8'h20};
    bq_t         s;
    int unsigned n;
    do_reload();
    s = make_stream(p);
    send_stream(s, 1'b0);
    wait_run(n);
    checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL csum_good_run: got %0b want 1", cpu_run); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL csum_good_err: got %0b want 0", load_err); end
    do_reload();
    s[s.size()-1] = s[s.size()-1] ^ 8'h01;
    send_stream(s, 1'b0);
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL csum_bad_err: got %0b want 1", load_err); end
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL csum_bad_run: got %0b want 0", cpu_run); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL csum_bad_ready: got %0b want 0", in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL csum_bad_run_late: got %0b want 0", cpu_run); end
    commit_model(p);
  endtask
`else
  task automatic test_checksum();
    bq_t         p = '{8'h10, 8'h20};
    int unsigned n;
    int unsigned we0;
    do_reload();
    send_stream(make_stream(p), 1'b0);
    wait_run(n);
    checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL nocsum_run: got %0b want 1", cpu_run); end
    we0      = we_count;
    in_valid = 1'b1;
    in_data  = 8'h30;
    repeat (4) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL nocsum_ready: got %0b want 0", in_ready); end
    in_valid = 1'b0;
    checks++; if (byte_count !== 11'd2) begin errors++; $display("FAIL nocsum_count: got %0d want 2", byte_count); end
    checks++; if (we_count != we0) begin errors++; $display("FAIL nocsum_extra_write: got %0d want 0", we_count - we0); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL nocsum_err: got %0b want 0", load_err); end
    commit_model(p);
  endtask
`endif

  task automatic test_reset_midload();
    bq_t         p;
    bq_t         p2;
    bq_t         s;
    int unsigned n;
    do_reload();
    p = rand_payload(10);
    s = make_stream(p);
    for (int i = 0; i < 7; i++) send_byte(s[i]);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %0b want 1", in_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_mem_we: got %0b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL mid_mem_addr: got %0h want 0", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL mid_mem_wdata: got %0h want 0", mem_wdata); end
    checks++; if (byte_count !== '0) begin errors++; $display("FAIL mid_byte_count: got %0d want 0", byte_count); end
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL mid_cpu_run: got %0b want 0", cpu_run); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL mid_load_err: got %0b want 0", load_err); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) exp_mem[i] = p[i];
    p2 = rand_payload(2);
    send_stream(make_stream(p2), 1'b0);
    wait_run(n);
    checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL mid_fresh_run: got %0b want 1", cpu_run); end
    checks++; if (byte_count !== 11'd2) begin errors++; $display("FAIL mid_fresh_count: got %0d want 2", byte_count); end
    commit_model(p2);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin
        errors++; $display("FAIL mid_mem[%0d]: got %0h want %0h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_reload_ignored();
    bq_t         p;
    bq_t         s;
    int unsigned n;
    do_reload();
    p = rand_payload(4);
    s = make_stream(p);
    for (int i = 0; i < 4; i++) send_byte(s[i]);
    do_reload();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rld_in_ready: got %0b want 1", in_ready); end
    checks++; if (byte_count !== 11'd2) begin errors++; $display("FAIL rld_count_mid: got %0d want 2", byte_count); end
    for (int i = 4; i < s.size(); i++) send_byte(s[i]);
    wait_run(n);
    checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL rld_run: got %0b want 1", cpu_run); end
    checks++; if (byte_count !== 11'd4) begin errors++; $display("FAIL rld_count: got %0d want 4", byte_count); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL rld_err: got %0b want 0", load_err); end
    commit_model(p);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin
        errors++; $display("FAIL rld_mem[%0d]: got %0h want %0h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_max_len();
    test_random_gaps();
    test_oversize();
    test_checksum();
    test_reset_midload();
    test_reload_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
